r_point_empty_fwft: RTL

//  Read-clock-domain side of the depth-8 async FIFO: read pointer (binary + Gray), registered empty

---
 rtl/r_point_empty_fwft.sv | 98 +++++++++
 1 files changed

// File: rtl/r_point_empty_fwft.sv
// Read-domain side of the depth-8 async FIFO: Gray/binary read pointer, empty flag, fill level,
// and a first-word-fall-through output register with a valid/ready handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | output register holds no word; out_valid=0
// ST_VALID | output register holds a word for the consumer; out_valid=1
module r_point_empty_fwft #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  r_clk,
    input  logic                  r_rstn,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    input  logic [DATA_WIDTH-1:0] r_data_mem,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   r_point,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  r_empty,
    output logic [ADDR_WIDTH:0]   r_level,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int PW = ADDR_WIDTH + 1;

    typedef enum logic {ST_EMPTY, ST_VALID} out_state_t;

    out_state_t    out_state;
    logic [PW-1:0] r_binary_reg;
    logic [PW-1:0] r_binary_next;
    logic [PW-1:0] r_gray_next;
    logic [PW-1:0] wptr_bin;
    logic          pop;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Pop depends only on registered empty, so the memory can never be underflowed.
    assign pop           = ~r_empty & (~out_valid | out_ready);
    assign r_binary_next = r_binary_reg + {{(PW-1){1'b0}}, pop};
    assign r_gray_next   = (r_binary_next >> 1) ^ r_binary_next;
    assign wptr_bin      = gray2bin(rq2_wptr);
    assign r_addr        = r_binary_reg[ADDR_WIDTH-1:0];

    always_ff @(posedge r_clk or negedge r_rstn) begin
        if (!r_rstn) begin
            r_binary_reg <= '0;
            r_point      <= '0;
            r_empty      <= 1'b1;
            r_level      <= '0;
        end else begin
            r_binary_reg <= r_binary_next;
            r_point      <= r_gray_next;
            r_empty      <= (r_gray_next == rq2_wptr);
            r_level      <= wptr_bin - r_binary_next;
        end
    end

    always_ff @(posedge r_clk or negedge r_rstn) begin
        if (!r_rstn) begin
            out_state <= ST_EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (out_state)
                ST_EMPTY: begin
                    if (pop) begin
                        out_data  <= r_data_mem;
                        out_valid <= 1'b1;
                        out_state <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (out_ready) begin
                        if (pop) begin
                            out_data <= r_data_mem;
                        end else begin
                            out_valid <= 1'b0;
                            out_state <= ST_EMPTY;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    out_state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule
